// File: rtl/gyro_debug_pkg.sv
// gyro_debug_pkg: shared state type, word width and helpers for the gyro debug scheduler.
package gyro_debug_pkg;
   typedef enum logic [1:0] {COUNT, SNAPSHOT, CLEAR, DRAIN} state_e;
   localparam int DEBUG_WORD_W = 32;
   localparam logic [7:0] OVERRUN_MAX = 8'hff;
   function automatic int beat_idx_w(input int num_channels);
      return (num_channels > 1) ? $clog2(2 * num_channels) : 1;
   endfunction
endpackage

// File: rtl/gyro_debug_snapshot_buf.sv
// gyro_debug_snapshot_buf: holds both debug words of every channel, parallel load, indexed read.
module gyro_debug_snapshot_buf
   import gyro_debug_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int IDX_W        = beat_idx_w(NUM_CHANNELS)
) (
   input  logic                                 clock,
   input  logic                                 load,
   input  logic [DEBUG_WORD_W*NUM_CHANNELS-1:0] word_0_in,
   input  logic [DEBUG_WORD_W*NUM_CHANNELS-1:0] word_1_in,
   input  logic [IDX_W-1:0]                     rd_idx,
   output logic [DEBUG_WORD_W-1:0]              rd_data
);
   logic [DEBUG_WORD_W-1:0] mem_q [2*NUM_CHANNELS];
   logic [DEBUG_WORD_W-1:0] mem_d [2*NUM_CHANNELS];
   // entry 2c holds channel c word_0, entry 2c+1 its word_1, matching beat order
   always_comb begin
      mem_d = mem_q;
      if (load)
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            mem_d[2*c]   = word_0_in[DEBUG_WORD_W*c +: DEBUG_WORD_W];
            mem_d[2*c+1] = word_1_in[DEBUG_WORD_W*c +: DEBUG_WORD_W];
         end
   end
   always_ff @(posedge clock) mem_q <= mem_d;
   assign rd_data = mem_q[rd_idx];
endmodule

// File: rtl/gyro_debug_scheduler.sv
// gyro_debug_scheduler: windowed snapshot / clear / drain sequencer for the gyro channel debuggers.
module gyro_debug_scheduler
   import gyro_debug_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int PERIOD_W     = 24,
   parameter int CLEAR_CYCLES = 4
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 enable,
   input  logic                                 trigger,
   input  logic [PERIOD_W-1:0]                  period,
   input  logic [DEBUG_WORD_W*NUM_CHANNELS-1:0] debug_word_0_in,
   input  logic [DEBUG_WORD_W*NUM_CHANNELS-1:0] debug_word_1_in,
   output logic                                 debug_clear,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [DEBUG_WORD_W-1:0]              out_data,
   output logic [3:0]                           out_channel,
   output logic                                 out_word_sel,
   output logic                                 out_last,
   output logic                                 busy,
   output logic [7:0]                           overrun_count
);
   localparam int IDX_W = beat_idx_w(NUM_CHANNELS);
   localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(2*NUM_CHANNELS-1);
   localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES-1);

   state_e                  state_q, state_d;
   logic [PERIOD_W-1:0]     timer_q, timer_d;
   logic [CNT_W-1:0]        clr_cnt_q, clr_cnt_d;
   logic [IDX_W-1:0]        beat_q, beat_d;
   logic                    debug_clear_q, debug_clear_d;
   logic                    out_valid_q, out_valid_d;
   logic [DEBUG_WORD_W-1:0] out_data_q, out_data_d;
   logic [3:0]              out_channel_q, out_channel_d;
   logic                    out_word_sel_q, out_word_sel_d;
   logic                    out_last_q, out_last_d;
   logic                    busy_q, busy_d;
   logic [7:0]              overrun_q, overrun_d;
   logic                    expire, xfer, enter_snap, enter_drain, advance, load_beat;
   logic [IDX_W-1:0]        rd_idx;
   logic [DEBUG_WORD_W-1:0] rd_data;

   assign expire      = enable && (period != '0) && (timer_q == period - PERIOD_W'(1));
   assign xfer        = out_valid_q && out_ready;
   assign enter_snap  = (state_q == COUNT) && (state_d == SNAPSHOT);
   assign enter_drain = (state_q == CLEAR) && (state_d == DRAIN);
   assign advance     = (state_q == DRAIN) && xfer && !out_last_q;
   assign load_beat   = enter_drain || advance;
   assign rd_idx      = advance ? beat_q + IDX_W'(1) : '0;

   gyro_debug_snapshot_buf #(.NUM_CHANNELS(NUM_CHANNELS), .IDX_W(IDX_W)) u_buf (
      .clock     (clock),
      .load      (state_q == SNAPSHOT),
      .word_0_in (debug_word_0_in),
      .word_1_in (debug_word_1_in),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= COUNT;
         timer_q        <= '0;
         clr_cnt_q      <= '0;
         beat_q         <= '0;
         debug_clear_q  <= 1'b0;
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         out_channel_q  <= '0;
         out_word_sel_q <= 1'b0;
         out_last_q     <= 1'b0;
         busy_q         <= 1'b0;
         overrun_q      <= '0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         clr_cnt_q      <= clr_cnt_d;
         beat_q         <= beat_d;
         debug_clear_q  <= debug_clear_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         out_channel_q  <= out_channel_d;
         out_word_sel_q <= out_word_sel_d;
         out_last_q     <= out_last_d;
         busy_q         <= busy_d;
         overrun_q      <= overrun_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         COUNT:    state_d = (expire || trigger) ? SNAPSHOT : COUNT;
         SNAPSHOT: state_d = CLEAR;
         CLEAR:    state_d = (clr_cnt_q == CLEAR_LAST) ? DRAIN : CLEAR;
         DRAIN:    state_d = (xfer && out_last_q) ? COUNT : DRAIN;
         default:  state_d = COUNT;
      endcase
   end

   // an expiry outside COUNT is a lost window: count it and wrap the timer, no new snapshot
   always_comb begin
      timer_d        = (enter_snap || enter_drain || (expire && state_q != COUNT)) ? '0
                     : enable ? timer_q + PERIOD_W'(1) : timer_q;
      overrun_d      = (expire && state_q != COUNT && overrun_q != OVERRUN_MAX) ? overrun_q + 8'd1 : overrun_q;
      clr_cnt_d      = (state_q == CLEAR) ? clr_cnt_q + CNT_W'(1) : '0;
      beat_d         = load_beat ? rd_idx : beat_q;
      out_data_d     = load_beat ? rd_data : out_data_q;
      out_channel_d  = load_beat ? 4'(rd_idx >> 1) : out_channel_q;
      out_word_sel_d = load_beat ? rd_idx[0] : out_word_sel_q;
      out_last_d     = load_beat ? (rd_idx == LAST_IDX) : out_last_q;
      out_valid_d    = state_d == DRAIN;
      debug_clear_d  = state_d == CLEAR;
      busy_d         = state_d != COUNT;
   end

   assign debug_clear   = debug_clear_q;
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_channel   = out_channel_q;
   assign out_word_sel  = out_word_sel_q;
   assign out_last      = out_last_q;
   assign busy          = busy_q;
   assign overrun_count = overrun_q;
endmodule

// File: tb/tb_gyro_debug_scheduler.sv
// tb_gyro_debug_scheduler: directed plus randomized bench checked against a behavioural model.
module tb_gyro_debug_scheduler;
   localparam int NC  = 4;
   localparam int NB  = 2 * NC;
   localparam int CLR = 4;

   logic clock = 0, reset = 1, enable = 0, trigger = 0, out_ready = 0;
   logic [23:0] period = '0;
   logic [32*NC-1:0] w0 = '0, w1 = '0;
   logic debug_clear, out_valid, out_word_sel, out_last, busy;
   logic [31:0] out_data;
   logic [3:0] out_channel;
   logic [7:0] overrun_count;

   int checks = 0, failures = 0;
   bit model_on = 0, m_valid = 0, rand_words = 0, prev_clr = 0;
   int m_age = -1, m_pos = 0, m_overrun = 0;
   logic [23:0] m_timer = '0;
   logic [31:0] m_buf [NB];
   int clr_rises = 0, xfers = 0, last_xfers = 0;

   gyro_debug_scheduler #(.NUM_CHANNELS(NC), .PERIOD_W(24), .CLEAR_CYCLES(CLR)) dut (
      .clock(clock), .reset(reset), .enable(enable), .trigger(trigger), .period(period),
      .debug_word_0_in(w0), .debug_word_1_in(w1), .debug_clear(debug_clear),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_channel(out_channel), .out_word_sel(out_word_sel), .out_last(out_last),
      .busy(busy), .overrun_count(overrun_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30) $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic set_pattern();
      for (int c = 0; c < NC; c++) begin
         w0[32*c +: 32] = 32'hC0DE0000 | 32'(c);
         w1[32*c +: 32] = 32'hBEEF0000 | 32'(c);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if (rand_words)
         for (int c = 0; c < NC; c++) begin
            w0[32*c +: 32] = $urandom;
            w1[32*c +: 32] = $urandom;
         end
   endtask

   // m_age: cycles since the snapshot cycle (-1 while counting); beats follow the clear run
   task automatic model_step();
      bit expire, xfer;
      if (reset) begin
         model_on = 1; m_age = -1; m_pos = 0; m_overrun = 0; m_valid = 0; m_timer = '0;
      end else if (model_on) begin
         expire = enable && period != 0 && m_timer == period - 24'd1;
         if (m_age < 0) begin
            if (expire || trigger) begin
               m_age = 0; m_timer = '0;
            end else if (enable) m_timer = m_timer + 24'd1;
         end else begin
            xfer = m_valid && out_ready;
            if (expire) begin
               m_overrun = (m_overrun < 255) ? m_overrun + 1 : 255;
               m_timer = '0;
            end else if (enable) m_timer = m_timer + 24'd1;
            if (m_age == 0)
               for (int i = 0; i < NB; i++) m_buf[i] = (i % 2 == 0) ? w0[32*(i/2) +: 32] : w1[32*(i/2) +: 32];
            m_age++;
            if (m_age == CLR + 1) begin
               m_timer = '0; m_valid = 1; m_pos = 0;
            end else if (xfer) begin
               if (m_pos == NB - 1) begin
                  m_valid = 0; m_age = -1;
               end else m_pos++;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clock);
      model_step();
   end

   initial forever begin
      @(negedge clock);
      if (model_on) begin
         check("debug_clear", debug_clear, m_age >= 1 && m_age <= CLR);
         check("busy", busy, m_age >= 0);
         check("out_valid", out_valid, m_valid);
         check("overrun_count", overrun_count, m_overrun);
         if (m_valid) begin
            check("out_data", out_data, m_buf[m_pos]);
            check("out_channel", out_channel, m_pos / 2);
            check("out_word_sel", out_word_sel, m_pos % 2);
            check("out_last", out_last, m_pos == NB - 1);
         end
         if (debug_clear && !prev_clr) clr_rises++;
         prev_clr = debug_clear;
         if (out_valid && out_ready && !reset) begin
            xfers++;
            if (out_last) last_xfers++;
         end
      end
   end

   task automatic drain_window(input int budget, output int nx, output int nl, output int nr);
      int x0 = xfers, l0 = last_xfers, r0 = clr_rises, ph = 0;
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         out_ready = (ph % 4 == 0) || (ph % 4 == 3);
         ph++;
         @(negedge clock);
         if (busy) seen = 1;
         if (seen && !busy) break;
      end
      nx = xfers - x0; nl = last_xfers - l0; nr = clr_rises - r0;
   endtask

   initial begin
      int n, nx, nl, nr, r0, x0, b;
      logic [31:0] ew;
      set_pattern();
      repeat (3) tick();
      @(negedge clock);
      check("rst_out_valid", out_valid, 0);
      check("rst_debug_clear", debug_clear, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun_count, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_channel", out_channel, 0);
      check("rst_out_word_sel", out_word_sel, 0);
      check("rst_out_last", out_last, 0);

      tick();
      reset = 0; period = 24'd100; enable = 1; out_ready = 1;
      n = 0;
      do begin
         tick(); n++; @(negedge clock);
      end while (!busy && n < 300);
      check("snapshot_cycle", n, 100);
      check("snapshot_no_clear", debug_clear, 0);
      for (int k = 101; k <= 113; k++) begin
         tick(); @(negedge clock);
         check("win_clear", debug_clear, k <= 104);
         check("win_valid", out_valid, k >= 105 && k <= 112);
         if (k >= 105 && k <= 112) begin
            b = k - 105;
            ew = (b % 2) ? (32'hBEEF0000 | 32'(b / 2)) : (32'hC0DE0000 | 32'(b / 2));
            check("win_data", out_data, ew);
            check("win_channel", out_channel, b / 2);
            check("win_last", out_last, b == 7);
         end
         if (k == 112) check("final_beat", out_data, 32'hBEEF0003);
      end

      drain_window(400, nx, nl, nr);
      check("bp_beats", nx, 8);
      check("bp_last", nl, 1);
      check("bp_snapshots", nr, 1);

      out_ready = 1; period = '0;
      r0 = clr_rises;
      repeat (1000) tick();
      @(negedge clock);
      check("period0_no_snapshot", clr_rises - r0, 0);
      check("period0_idle", busy, 0);
      tick(); trigger = 1;
      tick(); trigger = 0;
      @(negedge clock);
      check("trig_snapshot", busy, 1);
      check("trig_snapshot_clear", debug_clear, 0);
      for (int k = 0; k < CLR + 1; k++) begin
         tick(); @(negedge clock);
         check("trig_clear", debug_clear, k < CLR);
      end
      check("trig_drain_start", out_valid, 1);
      repeat (12) tick();

      reset = 1; tick();
      reset = 0; period = 24'd10; out_ready = 0; enable = 1;
      n = 0;
      do begin
         tick(); n++; @(negedge clock);
      end while (!out_valid && n < 100);
      check("ovr_drain_start", n, 15);
      repeat (9) begin
         tick(); @(negedge clock);
      end
      check("ovr_before", overrun_count, 0);
      tick(); @(negedge clock);
      check("ovr_first", overrun_count, 1);
      r0 = clr_rises;
      repeat (3000) tick();
      @(negedge clock);
      check("ovr_saturate", overrun_count, 255);
      check("ovr_no_clear", clr_rises - r0, 0);
      check("ovr_beat_held", out_data, 32'hC0DE0000);
      out_ready = 1;
      repeat (12) tick();

      reset = 1; tick();
      reset = 0; period = 24'd20; out_ready = 1; enable = 1;
      r0 = clr_rises;
      repeat (19) tick();
      trigger = 1; tick();
      trigger = 0; enable = 0;
      @(negedge clock);
      check("coinc_snapshot", busy, 1);
      n = 0;
      do begin
         tick(); n++; @(negedge clock);
      end while (!debug_clear && n < 20);
      tick(); trigger = 1;
      tick(); trigger = 0;
      repeat (40) tick();
      @(negedge clock);
      check("coinc_one_snapshot", clr_rises - r0, 1);
      check("coinc_overrun", overrun_count, 0);
      check("coinc_idle", busy, 0);

      tick(); reset = 1;
      tick(); reset = 0; period = 24'd30; enable = 1; out_ready = 1;
      x0 = xfers; n = 0;
      do begin
         tick(); n++; @(negedge clock);
      end while (xfers - x0 < 3 && n < 100);
      tick(); reset = 1;
      tick(); reset = 0;
      @(negedge clock);
      check("abort_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_clear", debug_clear, 0);
      check("abort_data", out_data, 0);
      check("abort_channel", out_channel, 0);
      check("abort_last", {out_word_sel, out_last}, 0);
      x0 = xfers; nl = last_xfers; n = 0;
      do begin
         tick(); n++; @(negedge clock);
      end while (last_xfers == nl && n < 200);
      check("abort_next_beats", xfers - x0, 8);
      repeat (3) tick();

      rand_words = 1; period = 24'd12;
      for (int i = 0; i < 4000; i++) begin
         tick();
         enable    = ($urandom_range(0, 7) != 0);
         trigger   = ($urandom_range(0, 39) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         reset     = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 149) == 0) period = 24'($urandom_range(0, 30));
      end
      tick(); reset = 0; trigger = 0;
      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gyro_debug_scheduler.md
Name: gyro_debug_scheduler

Overview:
Sequences the per-channel gyro event-counter debuggers on a fixed measurement window. At each window end (or on a software trigger) it snapshots every channel's two debug words, then pulses the shared debug clear so the counters restart for the next window. It then streams the snapshot out over a valid/ready interface to the register/DMA side. It sits between the channel debuggers and the host-facing debug readout.

Parameters:
NUM_CHANNELS, 4, number of channel debuggers served (1..16)
PERIOD_W, 24, width of the window-length input
CLEAR_CYCLES, 4, cycles debug_clear is held high (covers the ripple counters' async clear)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  window timer runs while high
trigger  input  1  one-cycle request for an immediate snapshot
period  input  PERIOD_W  window length in clock cycles; 0 = timer never expires (trigger only)
debug_word_0_in  input  32*NUM_CHANNELS  channel c occupies bits [32c+31:32c]
debug_word_1_in  input  32*NUM_CHANNELS  same packing
debug_clear  output  1  clear to all channel debuggers
out_valid  output  1  snapshot beat available
out_ready  input  1  consumer accepts beat
out_data  output  32  snapshot word
out_channel  output  4  channel index of beat
out_word_sel  output  1  0 = word_0, 1 = word_1
out_last  output  1  final beat of snapshot
busy  output  1  high in SNAPSHOT, CLEAR, DRAIN
overrun_count  output  8  saturating count of windows lost to a busy drain

Behaviour:
- Reset values: state=COUNT, timer=0, debug_clear=0, out_valid=0, out_data=0, out_channel=0, out_word_sel=0, out_last=0, busy=0, overrun_count=0. Reset mid-operation aborts any drain. The snapshot buffer is not cleared.
- All outputs are registered.
- States: COUNT, SNAPSHOT, CLEAR, DRAIN.
- COUNT: while enable=1, the timer increments each cycle. Expiry is timer==period-1 with period!=0. Expiry or trigger=1 moves to SNAPSHOT next cycle and zeroes the timer. While enable=0 the timer holds, but trigger is still honoured.
- SNAPSHOT: exactly one cycle. Registers all 2*NUM_CHANNELS input words into the buffer. The next state is CLEAR.
- CLEAR: debug_clear=1 for exactly CLEAR_CYCLES consecutive cycles, starting the cycle after SNAPSHOT. It then enters DRAIN, and the timer restarts from 0 on the first DRAIN cycle.
- DRAIN:
  - The window timer keeps running when enable=1.
  - Beats are emitted in order ch0 w0, ch0 w1, ch1 w0, …, ch(N-1) w1: 2*NUM_CHANNELS beats in total.
  - out_valid rises on the first DRAIN cycle.
  - A beat transfers when out_valid and out_ready are both high. On transfer the next beat is presented the following cycle with no bubble.
  - out_data, out_channel, out_word_sel and out_last are stable while out_valid=1 and out_ready=0.
  - out_last=1 only on the final beat. After it transfers: out_valid=0, and the next state is COUNT with the timer value kept.
- Window expiry during SNAPSHOT/CLEAR/DRAIN (overrun):
  - overrun_count increments, saturating at 255.
  - The timer wraps to 0.
  - No additional snapshot is taken.
  - Counters are not cleared.
- trigger outside COUNT is ignored and not counted. Expiry and trigger in the same COUNT cycle produce a single snapshot.
- Changing period while counting takes effect immediately. If timer ≥ new period-1, expiry occurs on the next compare that matches after wrap; the timer wraps at 2^PERIOD_W.
- enable falling during SNAPSHOT/CLEAR/DRAIN does not abort the sequence.

Decomposition:
- Shared package gyro_debug_pkg:
  - state enum (COUNT, SNAPSHOT, CLEAR, DRAIN)
  - DEBUG_WORD_W=32
  - beat-index width function
  - overrun saturation constant
- Natural sub-module: gyro_debug_snapshot_buf. It holds the 2*NUM_CHANNELS×32 registers with a parallel load and an indexed read port.
- The FSM, window timer and output register stay in the top.

Test Plan:
- NUM_CHANNELS=4, period=100, enable=1, out_ready=1, ch c words = 0xC0DE000c / 0xBEEF000c:
  - SNAPSHOT on cycle 100 after reset release.
  - debug_clear high for cycles 101–104.
  - 8 beats in order, out_last on the 8th (0xBEEF0003).
- Drain back-pressure: out_ready toggles 1,0,0,1 → each beat held stable while stalled; all 8 beats delivered once, in order, with no duplicates.
- period=0, enable=1, no trigger for 1000 cycles → no snapshot. trigger pulse → SNAPSHOT next cycle, debug_clear 4 cycles.
- Overrun: period=10, out_ready=0 → overrun_count reaches 1 after 10 drain cycles. Held for 3000 cycles → saturates at 255 and debug_clear is never re-pulsed.
- trigger asserted in the same cycle as expiry → exactly one snapshot, overrun_count=0. trigger during CLEAR → ignored.
- reset asserted mid-DRAIN after beat 3 → next cycle all outputs are at reset values and the state is COUNT. The next window produces a full 8-beat snapshot.
